// File: rtl/sr_write_queue.sv
// SR write queue: buffers SR write requests and drains them in order, one per cycle, into the SR file write port.
// Defining SR_WRITE_QUEUE_BYPASS_EN builds the youngest-match bypass lookup; otherwise the lookup outputs are tied to zero.

`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 5
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif

module sr_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst_n,
    input  logic                        iw_req_valid,
    input  logic [`HBIT_TGT_GP:0]       iw_req_addr,
    input  logic [`HBIT_DATA:0]         iw_req_data,
    output logic                        ow_req_ready,
    input  logic                        iw_drain_en,
    input  logic                        iw_flush,
    output logic                        ow_write_enable,
    output logic [`HBIT_TGT_GP:0]       ow_write_addr,
    output logic [`HBIT_DATA:0]         ow_write_data,
    input  logic [`HBIT_TGT_GP:0]       iw_lookup_addr1,
    input  logic [`HBIT_TGT_GP:0]       iw_lookup_addr2,
    output logic                        ow_lookup_hit1,
    output logic                        ow_lookup_hit2,
    output logic [`HBIT_DATA:0]         ow_lookup_data1,
    output logic [`HBIT_DATA:0]         ow_lookup_data2,
    output logic [$clog2(DEPTH):0]      ow_count,
    output logic                        ow_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = `HBIT_TGT_GP + 1;
    localparam int DW = `HBIT_DATA + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [RW-1:0] r_addr_mem [DEPTH];
    logic [DW-1:0] r_data_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Ready looks only at the registered count, so a full queue stays not-ready even while popping.
    assign w_push = iw_req_valid && !w_full && !iw_flush;
    assign w_pop  = !w_empty && iw_drain_en && !iw_flush;

    assign ow_req_ready    = !w_full;
    assign ow_empty        = w_empty;
    assign ow_count        = r_count;
    assign ow_write_enable = w_pop;
    assign ow_write_addr   = r_addr_mem[r_head];
    assign ow_write_data   = r_data_mem[r_head];

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (iw_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_addr_mem[r_tail] <= iw_req_addr;
            r_data_mem[r_tail] <= iw_req_data;
        end
    end

`ifdef SR_WRITE_QUEUE_BYPASS_EN
    // Walk from head to tail so a later (younger) match overwrites an earlier one.
    function automatic logic [DW:0] f_lookup(input logic [RW-1:0] q_addr);
        logic [DW:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + AW'(k);
            if ((CW'(k) < r_count) && (r_addr_mem[idx] == q_addr)) begin
                res = {1'b1, r_data_mem[idx]};
            end
        end
        return res;
    endfunction

    logic [DW:0] w_lookup1;
    logic [DW:0] w_lookup2;

    always_comb begin
        w_lookup1 = f_lookup(iw_lookup_addr1);
        w_lookup2 = f_lookup(iw_lookup_addr2);
    end

    assign ow_lookup_hit1  = w_lookup1[DW];
    assign ow_lookup_data1 = w_lookup1[DW-1:0];
    assign ow_lookup_hit2  = w_lookup2[DW];
    assign ow_lookup_data2 = w_lookup2[DW-1:0];
`else
    logic w_lookup_unused;
    assign w_lookup_unused = ^{iw_lookup_addr1, iw_lookup_addr2};

    assign ow_lookup_hit1  = 1'b0;
    assign ow_lookup_data1 = '0;
    assign ow_lookup_hit2  = 1'b0;
    assign ow_lookup_data2 = '0;
`endif

endmodule
